imem_loader: RTL and testbench

Boot-time writer for the CPU's 256-word instruction memory, which the core reads combinationally at word index PC[9:2].
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Drives a single write port into instruction memory.
- Holds the CPU in reset until the image is fully loaded.
- Sits beside the CPU top: its cpu_hold output is ORed into the core's rst.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The optional checksum state is only entered when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      LEN_LO = 3'd0,
      LEN_HI = 3'd1,
      DATA   = 3'd2,
      CHK    = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_t;

   localparam int IMEM_DEPTH = 256;
   localparam int HDR_LEN_W  = 16;

   // Running XOR of payload bytes, compared against the trailing checksum byte.
   function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects accepted stream bytes into little-endian 32-bit words.
// word_valid pulses in the cycle the fourth byte of a word is accepted.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        accept,
   input  logic [7:0]  in_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]      lane_cnt_r;
   logic [2:0][7:0] lane_r;

   // The top lane is never stored; the word is completed by the byte arriving now.
   always_comb begin
      word       = {in_byte, lane_r[2], lane_r[1], lane_r[0]};
      word_valid = accept && (lane_cnt_r == 2'd3);
   end

   // Lane counter and byte storage; lanes hold their value while no byte is offered.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane_cnt_r <= 2'd0;
         lane_r     <= '0;
      end else if (accept) begin
         lane_cnt_r <= lane_cnt_r + 2'd1;
         case (lane_cnt_r)
            2'd0:    lane_r[0] <= in_byte;
            2'd1:    lane_r[1] <= in_byte;
            2'd2:    lane_r[2] <= in_byte;
            default: lane_r    <= lane_r;
         endcase
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length header, payload words, CPU hold until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = $clog2(IMEM_DEPTH),
   parameter int LEN_W  = HDR_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(2 ** ADDR_W);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t END_ST = CHK;
`else
   localparam state_t END_ST = DONE;
`endif

   state_t              state_r, state_next_s;
   logic [LEN_W-1:0]    len_r, len_next_s, len_hi_s, wl_ext_s;
   logic                in_ready_r, in_ready_next_s;
   logic                imem_we_r;
   logic [ADDR_W-1:0]   imem_addr_r;
   logic [31:0]         imem_wdata_r;
   logic                cpu_hold_r, done_r, error_r;
   logic [ADDR_W:0]     words_loaded_r;
   logic                accept_s, data_accept_s, word_valid_s, last_byte_s;
   logic [31:0]         word_s;

   assign accept_s      = in_valid && in_ready_r;
   assign data_accept_s = accept_s && (state_r == DATA);
   assign len_hi_s      = LEN_W'({in_data, len_r[7:0]});
   assign wl_ext_s      = LEN_W'(words_loaded_r);
   assign last_byte_s   = word_valid_s && ((wl_ext_s + LEN_W'(1'b1)) == len_r);

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .accept     (data_accept_s),
      .in_byte    (in_data),
      .word_valid (word_valid_s),
      .word       (word_s)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum_r;

   // Accumulate the XOR of payload bytes only; header bytes are excluded.
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_r <= 8'd0;
      end else if (data_accept_s) begin
         csum_r <= xor_fold(csum_r, in_data);
      end
   end
`endif

   // Next-state, header capture and next-cycle ready decision.
   always_comb begin
      state_next_s    = state_r;
      len_next_s      = len_r;
      in_ready_next_s = 1'b0;
      case (state_r)
         LEN_LO: begin
            if (accept_s) begin
               len_next_s   = {len_r[LEN_W-1:8], in_data};
               state_next_s = LEN_HI;
            end else begin
               state_next_s = LEN_LO;
            end
         end
         LEN_HI: begin
            if (accept_s) begin
               len_next_s = len_hi_s;
               if (len_hi_s == '0) begin
                  state_next_s = END_ST;
               end else if (len_hi_s > MAX_WORDS) begin
                  state_next_s = ERR;
               end else begin
                  state_next_s = DATA;
               end
            end else begin
               state_next_s = LEN_HI;
            end
         end
         // Leave DATA only once the final word's write strobe is on the port.
         DATA: begin
            if (imem_we_r && (wl_ext_s == len_r)) begin
               state_next_s = END_ST;
            end else begin
               state_next_s = DATA;
            end
         end
         CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (accept_s) begin
               state_next_s = (in_data == csum_r) ? DONE : ERR;
            end else begin
               state_next_s = CHK;
            end
`else
            state_next_s = ERR;
`endif
         end
         DONE:    state_next_s = DONE;
         ERR:     state_next_s = ERR;
         default: state_next_s = ERR;
      endcase

      // Ready drops after the last payload byte so nothing slips in during its write.
      case (state_next_s)
         LEN_LO, LEN_HI, CHK: in_ready_next_s = 1'b1;
         DATA:                in_ready_next_s = !last_byte_s;
         DONE, ERR:           in_ready_next_s = 1'b0;
         default:             in_ready_next_s = 1'b0;
      endcase
   end

   // State, write port and status registers; reset drops any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= LEN_LO;
         len_r          <= '0;
         in_ready_r     <= 1'b0;
         imem_we_r      <= 1'b0;
         imem_addr_r    <= '0;
         imem_wdata_r   <= 32'h0000_0000;
         cpu_hold_r     <= 1'b1;
         done_r         <= 1'b0;
         error_r        <= 1'b0;
         words_loaded_r <= '0;
      end else begin
         state_r    <= state_next_s;
         len_r      <= len_next_s;
         in_ready_r <= in_ready_next_s;
         imem_we_r  <= word_valid_s;
         if (word_valid_s) begin
            imem_addr_r    <= words_loaded_r[ADDR_W-1:0];
            imem_wdata_r   <= word_s;
            words_loaded_r <= words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};
         end
         done_r     <= (state_next_s == DONE);
         error_r    <= (state_next_s == ERR);
         cpu_hold_r <= (state_next_s != DONE);
      end
   end

   assign in_ready     = in_ready_r;
   assign imem_we      = imem_we_r;
   assign imem_addr    = imem_addr_r;
   assign imem_wdata   = imem_wdata_r;
   assign cpu_hold     = cpu_hold_r;
   assign done         = done_r;
   assign error        = error_r;
   assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard checked at each imem_we pulse.
// Checksum scenarios are compiled in when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready, imem_we, cpu_hold, done, error;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [8:0]  words_loaded;

   imem_loader dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   wr_t         exp_q[$];
   logic [31:0] mem [256];
   logic [7:0]  csum = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (imem_we === 1'b1) mem[imem_addr] <= imem_wdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Every write strobe must match the oldest expected write, including its cycle.
   always @(negedge clk) begin
      wr_t e;
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we", imem_we, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", imem_addr, e.addr);
            check("wr_data", imem_wdata, e.data);
            check("wr_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output int tcyc);
      int n = 0;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $error("FAIL ready_timeout: observed in_ready=%b required 1", in_ready);
      end
      tcyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_len(input logic [15:0] n);
      int t;
      send_byte(n[7:0], t);
      send_byte(n[15:8], t);
   endtask

   task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input int gap);
      int t;
      for (int i = 0; i < 4; i++) begin
         if (gap > 0 && i > 0) repeat (gap) @(negedge clk);
         send_byte(w[8*i +: 8], t);
         csum = csum ^ w[8*i +: 8];
      end
      exp_q.push_back('{addr, w, t + 1});
   endtask

   task automatic send_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
      int t;
      send_byte(csum, t);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 32'd0);
      check("rst_imem_we", imem_we, 32'd0);
      check("rst_imem_addr", imem_addr, 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_cpu_hold", cpu_hold, 32'd1);
      check("rst_done", done, 32'd0);
      check("rst_error", error, 32'd0);
      check("rst_words_loaded", words_loaded, 32'd0);
      rst  = 1'b0;
      csum = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;

      // Reset state and ready rising the cycle after reset release.
      do_reset();
      @(negedge clk);
      check("ready_after_rst", in_ready, 32'd1);

      // Two-word gapless load.
      send_len(16'd2);
      send_word(8'd0, 32'h0010_0513, 0);
      send_word(8'd1, 32'h0000_006F, 0);
      @(negedge clk);
      check("we_pulse", imem_we, 32'd1);
      check("done_during_we", done, 32'd0);
      send_csum();
      @(negedge clk);
      check("load2_done", done, 32'd1);
      check("load2_hold", cpu_hold, 32'd0);
      check("load2_error", error, 32'd0);
      check("load2_words", words_loaded, 32'd2);
      check("load2_ready", in_ready, 32'd0);
      check("load2_we_low", imem_we, 32'd0);
      check("mem0", mem[0], 32'h0010_0513);
      check("mem1", mem[1], 32'h0000_006F);

      // Zero-length image completes without writes.
      do_reset();
      send_len(16'd0);
      send_csum();
      @(negedge clk);
      check("n0_done", done, 32'd1);
      check("n0_hold", cpu_hold, 32'd0);
      check("n0_words", words_loaded, 32'd0);

      // Oversized image is rejected.
      do_reset();
      send_len(16'h0101);
      @(negedge clk);
      check("big_error", error, 32'd1);
      check("big_hold", cpu_hold, 32'd1);
      check("big_ready", in_ready, 32'd0);
      check("big_done", done, 32'd0);
      repeat (3) @(negedge clk);
      check("big_error_sticky", error, 32'd1);

      // Exactly full depth is accepted.
      do_reset();
      send_len(16'h0100);
      @(negedge clk);
      check("full_error", error, 32'd0);
      check("full_ready", in_ready, 32'd1);

      // Gapped stream gives the same writes as the gapless one.
      do_reset();
      send_len(16'd2);
      send_word(8'd0, 32'h0010_0513, 2);
      send_word(8'd1, 32'h0000_006F, 2);
      @(negedge clk);
      send_csum();
      @(negedge clk);
      check("gap_done", done, 32'd1);
      check("gap_words", words_loaded, 32'd2);

      // Reset part-way through a three-word load, then a fresh one-word load.
      do_reset();
      send_len(16'd3);
      send_word(8'd0, 32'hA5A5_0001, 0);
      send_byte(8'h77, t);
      send_byte(8'h88, t);
      do_reset();
      send_len(16'd1);
      send_word(8'd0, 32'hDEAD_BEEF, 0);
      @(negedge clk);
      send_csum();
      @(negedge clk);
      check("rl_done", done, 32'd1);
      check("rl_words", words_loaded, 32'd1);
      check("rl_mem0", mem[0], 32'hDEAD_BEEF);
      check("rl_mem1_kept", mem[1], 32'h0000_006F);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Matching and mismatching checksum bytes.
      do_reset();
      send_len(16'd1);
      send_word(8'd0, 32'h4433_2211, 0);
      @(negedge clk);
      send_byte(8'h44, t);
      @(negedge clk);
      check("ck_ok_done", done, 32'd1);
      check("ck_ok_error", error, 32'd0);

      do_reset();
      send_len(16'd1);
      send_word(8'd0, 32'h4433_2211, 0);
      @(negedge clk);
      send_byte(8'h45, t);
      @(negedge clk);
      check("ck_bad_error", error, 32'd1);
      check("ck_bad_done", done, 32'd0);
      check("ck_bad_hold", cpu_hold, 32'd1);
      check("ck_bad_mem0", mem[0], 32'h4433_2211);
`endif

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
